// File: rtl/plab5_mcore_mem_resp_net_serializer_pkg.sv
// Shared types and message-field helpers for the memory-response-to-network serializer.
// Field layout: mem resp control = {type[2:0], opaque, len[1:0]}; net msg = {dest, src, opaque, payload}.
package plab5_mcore_mem_resp_net_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int          MEM_RESP_TYPE_NBITS = 3;
  localparam int          MEM_RESP_LEN_NBITS  = 2;
  localparam logic [2:0]  MEM_RESP_TYPE_READ  = 3'd0;

  function automatic int net_msg_nbits(input int payload_nbits, input int opaque_nbits,
                                       input int srcdest_nbits);
    return payload_nbits + opaque_nbits + 2 * srcdest_nbits;
  endfunction

  function automatic logic is_read(input logic [MEM_RESP_TYPE_NBITS-1:0] t);
    return t == MEM_RESP_TYPE_READ;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_resp_net_serializer.sv
// Serializes one cacheline memory response into word-sized network flits on a val/rdy stream.
// Domain tag travels with the line; data and tag are scrubbed when a burst ends with nothing behind it.
module plab5_mcore_mem_resp_net_serializer
  import plab5_mcore_mem_resp_net_serializer_pkg::*;
#(
  parameter int p_net_src           = 0,
  parameter int p_num_ports         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  parameter int p_cacheline_nwords  = 4,
  parameter int p_dest_from_opaque  = 1,
  parameter int p_fixed_dest        = 1,
  localparam int CW = MEM_RESP_TYPE_NBITS + p_mem_opaque_nbits + MEM_RESP_LEN_NBITS,
  localparam int OW = net_msg_nbits(CW, p_net_opaque_nbits, p_net_srcdest_nbits)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_domain,
  input  logic                                        in_val,
  output logic                                        in_rdy,
  input  logic [CW-1:0]                               in_msg_control,
  input  logic [p_cacheline_nwords*p_mem_data_nbits-1:0] in_msg_data,
  output logic                                        out_val,
  input  logic                                        out_rdy,
  output logic                                        out_domain,
  output logic [OW-1:0]                               out_msg_control,
  output logic [p_mem_data_nbits-1:0]                 out_msg_data
);

  localparam int MO = p_mem_opaque_nbits;
  localparam int MD = p_mem_data_nbits;
  localparam int NO = p_net_opaque_nbits;
  localparam int NS = p_net_srcdest_nbits;
  localparam int NW = p_cacheline_nwords;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  if (NO < IW || NS > MO || p_num_ports < 1) begin : g_bad_cfg
    $error("serializer: inconsistent net/mem field widths or port count");
  end

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_last;
  logic [MD-1:0]   r_words [NW];
  logic [CW-1:0]   r_ctrl;
  logic [NS-1:0]   r_dest;
  logic            r_domain;

  logic            w_last;
  logic            w_fire;
  logic            w_accept;
  logic            w_is_read;
  logic [NS-1:0]   w_dest_in;
  logic [NO-1:0]   w_idx_ext;

  assign w_is_read = is_read(in_msg_control[CW-1 -: MEM_RESP_TYPE_NBITS]);
  assign w_dest_in = (p_dest_from_opaque != 0) ? in_msg_control[MO+1 -: NS] : NS'(p_fixed_dest);
  assign w_idx_ext = NO'(r_idx);

  assign out_val  = (r_state == ST_SEND);
  assign w_last   = (r_idx == r_last);
  assign w_fire   = out_val & out_rdy;
  // Accept while idle, or on the final handshake of a burst so lines stream without a bubble.
  assign in_rdy   = reset & ((r_state == ST_IDLE) | (w_fire & w_last));
  assign w_accept = in_val & in_rdy;

  assign out_domain      = r_domain;
  assign out_msg_data    = r_words[r_idx];
  assign out_msg_control = out_val ? {r_dest, NS'(p_net_src), w_idx_ext, r_ctrl} : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_last   <= '0;
      r_ctrl   <= '0;
      r_dest   <= '0;
      r_domain <= 1'b0;
      for (int i = 0; i < NW; i++) r_words[i] <= '0;
    end else if (w_accept) begin
      r_state  <= ST_SEND;
      r_idx    <= '0;
      r_last   <= w_is_read ? IW'(NW - 1) : '0;
      r_ctrl   <= in_msg_control;
      r_dest   <= w_dest_in;
      r_domain <= in_domain;
      for (int i = 0; i < NW; i++) r_words[i] <= w_is_read ? in_msg_data[i*MD +: MD] : '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_state  <= ST_IDLE;
        r_idx    <= '0;
        r_ctrl   <= '0;
        r_dest   <= '0;
        r_domain <= 1'b0;
        for (int i = 0; i < NW; i++) r_words[i] <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_resp_net_serializer.sv
// Randomized scoreboard bench for the memory-response serializer with directed corner scenarios.
module tb_plab5_mcore_mem_resp_net_serializer;

  localparam int NW  = 4;
  localparam int MD  = 32;
  localparam int MO  = 8;
  localparam int NO  = 4;
  localparam int NS  = 3;
  localparam int SRC = 0;
  localparam int CW  = 3 + MO + 2;
  localparam int OW  = CW + NO + 2 * NS;
  localparam logic [2:0] T_READ  = 3'd0;
  localparam logic [2:0] T_WRITE = 3'd1;

  typedef struct packed {
    logic [OW-1:0] ctrl;
    logic [MD-1:0] data;
    logic          dom;
  } flit_t;

  logic              clk;
  logic              reset;
  logic              in_domain;
  logic              in_val;
  logic              in_rdy;
  logic [CW-1:0]     in_msg_control;
  logic [NW*MD-1:0]  in_msg_data;
  logic              out_val;
  logic              out_rdy;
  logic              out_domain;
  logic [OW-1:0]     out_msg_control;
  logic [MD-1:0]     out_msg_data;

  int    checks;
  int    failures;
  int    cyc;
  int    rdy_mode;
  flit_t exp_q[$];
  int    pop_cyc[$];

  plab5_mcore_mem_resp_net_serializer #(
    .p_net_src(SRC), .p_num_ports(4), .p_mem_opaque_nbits(MO), .p_mem_data_nbits(MD),
    .p_net_opaque_nbits(NO), .p_net_srcdest_nbits(NS), .p_cacheline_nwords(NW),
    .p_dest_from_opaque(1), .p_fixed_dest(1)
  ) dut (
    .clk(clk), .reset(reset), .in_domain(in_domain), .in_val(in_val), .in_rdy(in_rdy),
    .in_msg_control(in_msg_control), .in_msg_data(in_msg_data), .out_val(out_val),
    .out_rdy(out_rdy), .out_domain(out_domain), .out_msg_control(out_msg_control),
    .out_msg_data(out_msg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) out_rdy = 1'($urandom_range(0, 1));
      else if (rdy_mode == 2) out_rdy = ~out_rdy;
    end
  end

  // Monitor: every presented flit is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (out_val || in_rdy || out_msg_control != '0 || out_msg_data != '0 || out_domain) begin
        failures++;
        $display("FAIL reset_state: got val=%b rdy=%b ctrl=%h data=%h dom=%b, want all zero",
                 out_val, in_rdy, out_msg_control, out_msg_data, out_domain);
      end
    end else if (out_val) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_flit: got ctrl=%h data=%h dom=%b, want no flit",
                 out_msg_control, out_msg_data, out_domain);
      end else begin
        if (out_msg_control != exp_q[0].ctrl || out_msg_data != exp_q[0].data ||
            out_domain != exp_q[0].dom) begin
          failures++;
          $display("FAIL flit: got ctrl=%h data=%h dom=%b, want ctrl=%h data=%h dom=%b",
                   out_msg_control, out_msg_data, out_domain,
                   exp_q[0].ctrl, exp_q[0].data, exp_q[0].dom);
        end
        if (out_rdy) begin
          void'(exp_q.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
    end else begin
      checks++;
      if (out_msg_data != '0 || out_domain) begin
        failures++;
        $display("FAIL idle_clear: got data=%h dom=%b, want data=0 dom=0", out_msg_data, out_domain);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic push_expected(input logic [2:0] t, input logic [MO-1:0] op, input logic [1:0] ln,
                               input logic [NW*MD-1:0] d, input logic dom);
    flit_t          f;
    int             n;
    logic [NS-1:0]  src_v;
    logic [NS-1:0]  dest_v;
    n      = (t == T_READ) ? NW : 1;
    src_v  = NS'(SRC);
    dest_v = op[MO-1 -: NS];
    for (int i = 0; i < n; i++) begin
      f.ctrl = {dest_v, src_v, NO'(i), t, op, ln};
      f.data = (t == T_READ) ? d[i*MD +: MD] : '0;
      f.dom  = dom;
      exp_q.push_back(f);
    end
  endtask

  task automatic send_resp(input logic [2:0] t, input logic [MO-1:0] op, input logic [1:0] ln,
                           input logic [NW*MD-1:0] d, input logic dom, output int acc_cyc);
    int   w;
    logic accepted;
    w        = 0;
    accepted = 1'b0;
    acc_cyc  = -1;
    in_val         = 1'b1;
    in_msg_control = {t, op, ln};
    in_msg_data    = d;
    in_domain      = dom;
    while (!accepted && w < 500) begin
      @(negedge clk);
      if (in_rdy) begin
        @(posedge clk);
        accepted = 1'b1;
        push_expected(t, op, ln, d, dom);
      end else begin
        w++;
      end
    end
    #1;
    acc_cyc        = cyc;
    in_val         = 1'b0;
    in_msg_control = CW'($urandom);
    in_msg_data    = {$urandom, $urandom, $urandom, $urandom};
    in_domain      = 1'($urandom_range(0, 1));
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no in_rdy in 500 cycles, want acceptance");
    end
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int               a1;
    int               a2;
    logic [NW*MD-1:0] line;
    checks         = 0;
    failures       = 0;
    rdy_mode       = 0;
    reset          = 1'b0;
    in_val         = 1'b0;
    in_domain      = 1'b0;
    in_msg_control = '0;
    in_msg_data    = '0;
    out_rdy        = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("idle_in_rdy", 64'(in_rdy), 64'd1);
    gap(1);

    // Test 1: single READ, opaque 0x40 routes to dest 2, out_rdy held high.
    out_rdy = 1'b1;
    line = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    send_resp(T_READ, 8'h40, 2'd0, line, 1'b0, a1);
    for (int k = 0; k < NW; k++) begin
      @(negedge clk);
      check("t1_out_val", 64'(out_val), 64'd1);
      check("t1_in_rdy", 64'(in_rdy), (k == NW - 1) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    check("t1_done", 64'(out_val), 64'd0);
    gap(1);

    // Test 2: out_rdy toggling; the monitor verifies held outputs and ordering.
    rdy_mode = 2;
    send_resp(T_READ, 8'h40, 2'd1, line, 1'b1, a1);
    wait_drain("t2_drain");
    rdy_mode = 0;
    gap(1);
    out_rdy = 1'b1;
    gap(1);

    // Test 3: back-to-back READs with no bubble.
    pop_cyc.delete();
    send_resp(T_READ, 8'hA5, 2'd2, {$urandom, $urandom, $urandom, $urandom}, 1'b0, a1);
    send_resp(T_READ, 8'h3C, 2'd3, {$urandom, $urandom, $urandom, $urandom}, 1'b1, a2);
    check("t3_zero_bubble", 64'(a2 - a1), 64'(NW));
    wait_drain("t3_drain");
    check("t3_pop_count", 64'(pop_cyc.size()), 64'(2 * NW));
    for (int i = 0; i < pop_cyc.size() && i < 2 * NW; i++)
      check("t3_consecutive", 64'(pop_cyc[i] - a1), 64'(i));
    gap(1);

    // Test 4: WRITE gives a single zero-data flit and in_rdy during that flit.
    send_resp(T_WRITE, 8'hE7, 2'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, a1);
    @(negedge clk);
    check("t4_out_val", 64'(out_val), 64'd1);
    check("t4_in_rdy", 64'(in_rdy), 64'd1);
    @(negedge clk);
    check("t4_after_val", 64'(out_val), 64'd0);
    check("t4_after_rdy", 64'(in_rdy), 64'd1);
    gap(1);

    // Test 5: H line, idle gap (monitor checks scrubbed data/tag), then L line.
    send_resp(T_READ, 8'h80, 2'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, a1);
    wait_drain("t5_h_drain");
    gap(3);
    send_resp(T_READ, 8'h20, 2'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, a1);
    wait_drain("t5_l_drain");
    gap(1);

    // Test 6: asynchronous reset after the first flit drops the rest of the burst.
    send_resp(T_READ, 8'h40, 2'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, a1);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    #1 check("t6_async_val", 64'(out_val), 64'd0);
    gap(2);
    reset = 1'b1;
    @(negedge clk);
    check("t6_in_rdy", 64'(in_rdy), 64'd1);
    check("t6_out_val", 64'(out_val), 64'd0);
    repeat (4) @(negedge clk);
    gap(1);

    // Random phase: mixed response types, gaps and backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 150; n++) begin
      logic [2:0] t;
      t = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : T_READ;
      send_resp(t, 8'($urandom), 2'($urandom), {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 1)), a1);
      gap($urandom_range(0, 3));
    end
    rdy_mode = 0;
    gap(1);
    out_rdy = 1'b1;
    wait_drain("rand_drain");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
